// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single memory data port between the pipeline's stage-4
// load/store path and a debug/loader requester. The pipeline wins by
// default; a saturating starvation counter forces a debug grant after
// STARVE_MAX consecutive denied debug cycles (STARVE_MAX = 0 gives debug
// strict priority). Read data comes back one cycle after the grant and is
// steered to the requester that owned the read.
// Optional build macro: DMEM_ARB_STATS_EN adds stall/debug-grant counters.
module dmem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  output logic          mem_read,
  input  logic [DW-1:0] mem_q
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_stall_cnt,
  output logic [15:0]   stat_dbg_cnt
`endif
);

  // Counter must hold 0..STARVE_MAX; keep at least one bit when STARVE_MAX is 0.
  localparam int SCW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SCW-1:0] SMAX = SCW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    DBG_RD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SCW-1:0] starve_q, starve_d;
  logic [DW-1:0] cpu_hold_q, cpu_hold_d;
  logic [DW-1:0] dbg_hold_q, dbg_hold_d;

  logic cpu_gnt;
  logic dbg_gnt;
  logic cpu_rd_phase;
  logic dbg_rd_phase;

  // Grant decision; arbitration is suppressed while reset is held.
  always_comb begin
    dbg_gnt   = ~reset & dbg_req & (~cpu_req | (starve_q == SMAX));
    cpu_gnt   = ~reset & cpu_req & ~dbg_gnt;
    cpu_stall = cpu_req & ~cpu_gnt;
  end

  // Drive the memory data port from whichever requester holds the grant.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    mem_read  = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wren  = cpu_we;
      mem_read  = ~cpu_we;
    end else if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_wren  = dbg_we;
      mem_read  = ~dbg_we;
    end
  end

  // Starvation counter next value: count denied debug cycles, saturating.
  always_comb begin
    starve_d = '0;
    if (dbg_req & ~dbg_gnt) begin
      starve_d = (starve_q == SMAX) ? starve_q : starve_q + SCW'(1);
    end
  end

  // Response FSM next state: remember who owns the read returning next cycle.
  always_comb begin
    state_d = IDLE;
    if (cpu_gnt & ~cpu_we) begin
      state_d = CPU_RD;
    end else if (dbg_gnt & ~dbg_we) begin
      state_d = DBG_RD;
    end
  end

  // Response outputs; everything is forced to 0 while reset is asserted,
  // which also drops a read response that was in flight.
  always_comb begin
    cpu_rd_phase = ~reset & (state_q == CPU_RD);
    dbg_rd_phase = ~reset & (state_q == DBG_RD);
    cpu_hold_d   = cpu_rd_phase ? mem_q : cpu_hold_q;
    dbg_hold_d   = dbg_rd_phase ? mem_q : dbg_hold_q;
    cpu_rvalid   = cpu_rd_phase;
    dbg_ack      = dbg_rd_phase | (dbg_gnt & dbg_we);
    cpu_rdata    = reset ? '0 : cpu_hold_d;
    dbg_rdata    = reset ? '0 : dbg_hold_d;
  end

  // State, starvation counter and read-data hold registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      cpu_hold_q <= '0;
      dbg_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      cpu_hold_q <= cpu_hold_d;
      dbg_hold_q <= dbg_hold_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] dbg_cnt_q, dbg_cnt_d;

  // Saturating event counters for CPU stall cycles and debug grants.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    dbg_cnt_d   = dbg_cnt_q;
    if (cpu_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (dbg_gnt && (dbg_cnt_q != '1)) begin
      dbg_cnt_d = dbg_cnt_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      dbg_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      dbg_cnt_q   <= dbg_cnt_d;
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
  assign stat_dbg_cnt   = dbg_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a transaction-level model
// (shadow memory, pending-read record, denied-cycle count).
module tb_dmem_port_arbiter;
  localparam int SM = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       cpu_stall, cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       dbg_req, dbg_we;
  logic [7:0] dbg_addr, dbg_wdata;
  logic       dbg_ack;
  logic [7:0] dbg_rdata;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_wren, mem_read;
  logic [7:0] mem_q;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_stall_cnt, stat_dbg_cnt;
`endif

  dmem_port_arbiter #(.AW(8), .DW(8), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_read(mem_read), .mem_q(mem_q)
`ifdef DMEM_ARB_STATS_EN
    , .stat_stall_cnt(stat_stall_cnt), .stat_dbg_cnt(stat_dbg_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Memory attached to the data port: synchronous 1-cycle read.
  logic [7:0] tbmem [256];
  always @(posedge clock) begin
    if (mem_wren) tbmem[mem_addr] <= mem_wdata;
    mem_q <= tbmem[mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  logic [7:0] shadow [256];
  int         m_cnt;
  int         m_pend;   // 0 none, 1 CPU read returning, 2 debug read returning
  logic [7:0] m_paddr;
  logic [7:0] m_chold, m_dhold;
  bit         e_cg, e_dg;

  task automatic check_outputs();
    bit cg, dg;
    logic [7:0] ea, ed;
    bit ew, er;
    cg = 0; dg = 0;
    if (!reset) begin
      dg = dbg_req && (!cpu_req || m_cnt >= SM);
      cg = cpu_req && !dg;
    end
    e_cg = cg; e_dg = dg;
    ea = 8'h00; ed = 8'h00; ew = 0; er = 0;
    if (cg) begin
      ea = cpu_addr; ed = cpu_wdata; ew = cpu_we; er = !cpu_we;
    end else if (dg) begin
      ea = dbg_addr; ed = dbg_wdata; ew = dbg_we; er = !dbg_we;
    end
    check("cpu_stall", cpu_stall, cpu_req && !cg);
    check("mem_addr", mem_addr, ea);
    check("mem_wdata", mem_wdata, ed);
    check("mem_wren", mem_wren, ew);
    check("mem_read", mem_read, er);
    if (reset) begin
      check("cpu_rvalid", cpu_rvalid, 0);
      check("cpu_rdata", cpu_rdata, 0);
      check("dbg_ack", dbg_ack, 0);
      check("dbg_rdata", dbg_rdata, 0);
    end else begin
      check("cpu_rvalid", cpu_rvalid, m_pend == 1);
      check("cpu_rdata", cpu_rdata, (m_pend == 1) ? shadow[m_paddr] : m_chold);
      check("dbg_ack", dbg_ack, (m_pend == 2) || (dg && dbg_we));
      check("dbg_rdata", dbg_rdata, (m_pend == 2) ? shadow[m_paddr] : m_dhold);
    end
  endtask

  // Apply one cycle's inputs (just after the falling edge) and check outputs.
  task automatic drive(input bit rst, input bit cr, input bit cw, input logic [7:0] ca,
                       input logic [7:0] cd, input bit dr, input bit dw,
                       input logic [7:0] da, input logic [7:0] dd);
    reset = rst;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    #1;
    check_outputs();
  endtask

  // Advance through the rising edge and update the model.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      m_cnt = 0; m_pend = 0; m_chold = 8'h00; m_dhold = 8'h00;
    end else begin
      if (m_pend == 1) m_chold = shadow[m_paddr];
      else if (m_pend == 2) m_dhold = shadow[m_paddr];
      m_pend = 0;
      if (e_cg) begin
        if (cpu_we) shadow[cpu_addr] = cpu_wdata;
        else begin m_pend = 1; m_paddr = cpu_addr; end
      end else if (e_dg) begin
        if (dbg_we) shadow[dbg_addr] = dbg_wdata;
        else begin m_pend = 2; m_paddr = dbg_addr; end
      end
      if (dbg_req && !e_dg) m_cnt = (m_cnt >= SM) ? SM : m_cnt + 1;
      else m_cnt = 0;
    end
    @(negedge clock);
  endtask

  task automatic idle();
    drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
  endtask

  // CPU writes continuously while debug reads 0x30; debug must win at cycle 4 only.
  task automatic starve_scn();
    logic [7:0] exp_addr;
    for (int c = 0; c < 6; c++) begin
      drive(0, 1, 1, 8'h20, 8'(c + 1), (c < 5), 0, 8'h30, 8'h00);
      check("starve_stall", cpu_stall, (c == 4));
      exp_addr = (c == 4) ? 8'h30 : 8'h20;
      check("starve_addr", mem_addr, exp_addr);
      tick();
    end
    idle();
  endtask

  bit         rc_act, rc_we, rd_act, rd_we;
  logic [7:0] rc_a, rc_d, rd_a, rd_d;
  bit         rst_r;

  initial begin
    for (int i = 0; i < 256; i++) begin
      tbmem[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    m_cnt = 0; m_pend = 0; m_paddr = 8'h00; m_chold = 8'h00; m_dhold = 8'h00;
    reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    @(negedge clock);
    do_reset();
    // Stall follows cpu_req during reset.
    drive(1, 1, 0, 8'h05, 8'h00, 1, 0, 8'h06, 8'h00);
    check("reset_stall", cpu_stall, 1);
    tick();

    // CPU write then read back.
    drive(0, 1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00);
    check("wr_wren", mem_wren, 1);
    check("wr_stall", cpu_stall, 0);
    tick();
    drive(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    check("rd_rvalid", cpu_rvalid, 1);
    check("rd_rdata", cpu_rdata, 8'hA5);
    tick();

    // Debug-only read.
    drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
    check("dbg_gnt_read", mem_read, 1);
    tick();
    drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    check("dbg_rd_ack", dbg_ack, 1);
    check("dbg_rd_data", dbg_rdata, 8'hA5);
    tick();

    // Alternating CPU/debug reads, back to back.
    drive(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h11, 8'h5A); tick();
    drive(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00); tick();
    drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h11, 8'h00); tick();
    drive(0, 1, 0, 8'h11, 8'h00, 0, 0, 8'h00, 8'h00); tick();
    drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
    check("alt_cpu_data", cpu_rdata, 8'h5A);
    tick();
    drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    check("alt_dbg_data", dbg_rdata, 8'hA5);
    check("alt_no_rvalid", cpu_rvalid, 0);
    tick();

    // Reset in the cycle after a CPU read grant drops the response.
    drive(0, 1, 0, 8'h11, 8'h00, 0, 0, 8'h00, 8'h00); tick();
    drive(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    check("rst_rvalid", cpu_rvalid, 0);
    check("rst_rdata", cpu_rdata, 0);
    tick();
    drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    check("rst_dropped", cpu_rvalid, 0);
    tick();

    // Starvation scenario three times from a clean reset.
    do_reset();
    for (int k = 0; k < 3; k++) starve_scn();
`ifdef DMEM_ARB_STATS_EN
    check("stat_dbg", stat_dbg_cnt, 3);
    check("stat_stall", stat_stall_cnt, 3);
`endif

    // Random traffic honouring the hold-until-granted rule.
    rc_act = 0; rd_act = 0;
    rc_we = 0; rd_we = 0; rc_a = 0; rc_d = 0; rd_a = 0; rd_d = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!rc_act && ($urandom_range(2) != 0)) begin
        rc_act = 1; rc_we = $urandom_range(1) == 1;
        rc_a = 8'($urandom_range(15)); rc_d = 8'($urandom);
      end
      if (!rd_act && ($urandom_range(3) == 0)) begin
        rd_act = 1; rd_we = $urandom_range(1) == 1;
        rd_a = 8'($urandom_range(15)); rd_d = 8'($urandom);
      end
      rst_r = $urandom_range(63) == 0;
      drive(rst_r, rc_act, rc_we, rc_a, rc_d, rd_act, rd_we, rd_a, rd_d);
      tick();
      if (e_cg) rc_act = 0;
      if (e_dg) rd_act = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
